// File: rtl/a2d_spi_serf_pkg.sv
// Shared constants for the A2D SPI serf: frame layout, channel map and FSM states.
package a2d_pkg;

    localparam int A2D_FRAME_W = 16;

    // Command frame: [15:14] header (must be 00), [13:11] channel, [10:0] ignored
    localparam int CMD_HDR_MSB = 15;
    localparam int CMD_HDR_LSB = 14;
    localparam int CMD_CH_MSB  = 13;
    localparam int CMD_CH_LSB  = 11;

    localparam logic [2:0] CH_LFT_LD  = 3'd0;
    localparam logic [2:0] CH_RGHT_LD = 3'd4;
    localparam logic [2:0] CH_STEER   = 3'd5;
    localparam logic [2:0] CH_BATT    = 3'd6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        CHECK  = 2'd2
    } serf_state_t;

endpackage

// File: rtl/a2d_spi_serf_if.sv
// SPI link between the A2D monarch and this serf.
interface a2d_spi_serf_if;

    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    // SS_n/SCLK/MOSI are driven by the monarch; MISO by the serf. No handshake:
    // data is qualified by SS_n low and sampled on SCLK rising edges.
    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);

endinterface

// File: rtl/a2d_spi_serf_spi_sync_edge.sv
// Double-flop synchronizer with a third stage for single-clk rise/fall pulses.
module spi_sync_edge #(
    parameter logic IDLE_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic ff1, ff2, ff3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1 <= IDLE_VAL;
            ff2 <= IDLE_VAL;
            ff3 <= IDLE_VAL;
        end else begin
            ff1 <= din;
            ff2 <= ff1;
            ff3 <= ff2;
        end
    end

    assign sync = ff2;
    assign rise = ff2 & ~ff3;
    assign fall = ~ff2 & ff3;

endmodule

// File: rtl/a2d_spi_serf.sv
// A2D converter SPI serf: takes a channel command each frame and answers with
// that channel's conversion value on the following frame.
module a2d_spi_serf
    import a2d_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int DATA_W  = 12,
    parameter int FRAME_W = A2D_FRAME_W
) (
    input  logic                     clk,
    input  logic                     rst,
    a2d_spi_serf_if.slave            spi,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     cmd_vld,
    output logic [FRAME_W-1:0]       cmd_rcvd,
    output logic [2:0]               chnl,
    output logic                     xfer_err,
    output logic [1:0]               state
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_ACTIVE = ACTIVE;
    localparam logic [1:0] S_CHECK  = CHECK;

    logic ss_sync, ss_rise, ss_fall;
    logic sclk_sync, sclk_rise, sclk_fall;
    logic sclk_unused;
    logic mosi_ff1, mosi_sync;
    logic [FRAME_W-1:0] shft;
    logic [4:0] bit_cnt;
    logic [DATA_W-1:0] ch_sel;
    logic frame_good;

    spi_sync_edge #(.IDLE_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .din(spi.SS_n),
        .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.IDLE_VAL(1'b1)) u_sclk_sync (
        .clk(clk), .rst(rst), .din(spi.SCLK),
        .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
    );

    assign sclk_unused = &{1'b0, sclk_sync, sclk_fall};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_ff1  <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_ff1  <= spi.MOSI;
            mosi_sync <= mosi_ff1;
        end
    end

    // Channels at or beyond NUM_CH fall through to zero
    always_comb begin
        ch_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (chnl == 3'(k)) ch_sel = ch_data[k*DATA_W +: DATA_W];
        end
    end

    assign frame_good = (bit_cnt == 5'(FRAME_W)) &&
                        (shft[CMD_HDR_MSB:CMD_HDR_LSB] == 2'b00);

    // MISO changes a few clks after the SCLK rise the monarch samples on
    assign spi.MISO = ss_sync ? 1'b0 : shft[FRAME_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            shft     <= '0;
            bit_cnt  <= '0;
            chnl     <= '0;
            cmd_rcvd <= '0;
            cmd_vld  <= 1'b0;
            xfer_err <= 1'b0;
        end else begin
            cmd_vld  <= 1'b0;
            xfer_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ss_fall) begin
                        shft    <= FRAME_W'(ch_sel);
                        bit_cnt <= '0;
                        state   <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (ss_rise) begin
                        state <= S_CHECK;
                    end else if (sclk_rise && !ss_sync) begin
                        shft <= {shft[FRAME_W-2:0], mosi_sync};
                        if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                S_CHECK: begin
                    if (frame_good) begin
                        cmd_rcvd <= shft;
                        chnl     <= shft[CMD_CH_MSB:CMD_CH_LSB];
                        cmd_vld  <= 1'b1;
                    end else begin
                        xfer_err <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_spi_serf.sv
// Self-checking bench for a2d_spi_serf: drives SPI frames as the monarch and
// compares responses and pulses against a frame-level reference model.
module tb_a2d_spi_serf;
    import a2d_pkg::*;

    localparam int NUM_CH  = 8;
    localparam int DATA_W  = 12;
    localparam int FRAME_W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    a2d_spi_serf_if spi ();

    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     cmd_vld;
    logic [FRAME_W-1:0]       cmd_rcvd;
    logic [2:0]               chnl;
    logic                     xfer_err;
    logic [1:0]               state;

    a2d_spi_serf #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_W(FRAME_W)) dut (
        .clk(clk), .rst(rst), .spi(spi), .ch_data(ch_data),
        .cmd_vld(cmd_vld), .cmd_rcvd(cmd_rcvd), .chnl(chnl),
        .xfer_err(xfer_err), .state(state)
    );

    int checks = 0;
    int errors = 0;
    int vld_cnt = 0;
    int err_cnt = 0;

    always @(negedge clk) begin
        if (cmd_vld === 1'b1) vld_cnt++;
        if (xfer_err === 1'b1) err_cnt++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached (checks %0d)", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] chv [NUM_CH];
    logic [2:0]        m_chnl;
    logic [15:0]       m_cmd;

    function automatic logic [15:0] m_resp();
        return {4'h0, chv[m_chnl]};
    endfunction

    function automatic bit m_good(input logic [15:0] cmd, input int nbits);
        return (nbits == 16) && (cmd[15:14] == 2'b00);
    endfunction

    function automatic logic [15:0] m_mask(input int nbits);
        logic [15:0] ones;
        ones = 16'hFFFF;
        return (nbits >= 16) ? ones : ~(ones >> nbits);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_ch(input int k, input logic [DATA_W-1:0] v);
        chv[k] = v;
        ch_data[k*DATA_W +: DATA_W] = v;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        spi.SS_n = 1'b1;
        spi.SCLK = 1'b1;
        spi.MOSI = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        m_chnl = 3'd0;
        m_cmd  = 16'h0000;
    endtask

    // One monarch frame: SCLK half-period 5 clks, MOSI set on fall, MISO
    // sampled just before the rise. Optionally rewrites a channel one clk
    // after the serf has loaded its response.
    task automatic spi_frame(input logic [15:0] cmd, input int nbits,
                             input int upd_ch, input logic [DATA_W-1:0] upd_val,
                             output logic [15:0] rx, output int dv, output int de);
        int v0, e0;
        v0 = vld_cnt;
        e0 = err_cnt;
        rx = 16'h0000;
        @(negedge clk);
        spi.SS_n = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 3 && upd_ch >= 0) set_ch(upd_ch, upd_val);
        end
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            spi.SCLK = 1'b0;
            spi.MOSI = (i < 16) ? cmd[15-i] : 1'b0;
            repeat (4) @(negedge clk);
            if (i < 16) rx[15-i] = spi.MISO;
            @(negedge clk);
            spi.SCLK = 1'b1;
            repeat (4) @(negedge clk);
        end
        @(negedge clk);
        spi.SS_n = 1'b1;
        spi.MOSI = 1'b0;
        repeat (10) @(negedge clk);
        dv = vld_cnt - v0;
        de = err_cnt - e0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        spi.SS_n = 1'b1;
        spi.SCLK = 1'b1;
        spi.MOSI = 1'b0;
        for (int k = 0; k < NUM_CH; k++) set_ch(k, 12'h000);
        repeat (3) @(negedge clk);
        checks++; if (spi.MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", spi.MISO); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (chnl !== 3'd0) begin errors++; $display("FAIL reset_chnl got %0d want 0", chnl); end
        checks++; if (cmd_rcvd !== 16'h0000) begin errors++; $display("FAIL reset_cmd_rcvd got %h want 0000", cmd_rcvd); end
        checks++; if (cmd_vld !== 1'b0) begin errors++; $display("FAIL reset_cmd_vld got %b want 0", cmd_vld); end
        checks++; if (xfer_err !== 1'b0) begin errors++; $display("FAIL reset_xfer_err got %b want 0", xfer_err); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL post_reset_state got %0d want 0", state); end
        checks++; if (vld_cnt + err_cnt !== 0) begin errors++; $display("FAIL post_reset_pulses got %0d want 0", vld_cnt + err_cnt); end
        m_chnl = 3'd0;
        m_cmd  = 16'h0000;
    endtask

    task automatic test_basic();
        logic [15:0] cmds [2];
        logic [15:0] rx, exp_rx, mask;
        int dv, de;
        bit good;
        cmds[0] = 16'h2000;
        cmds[1] = 16'h0000;
        set_ch(4, 12'hA5C);
        for (int f = 0; f < 2; f++) begin
            exp_rx = m_resp(); good = m_good(cmds[f], 16); mask = m_mask(16);
            spi_frame(cmds[f], 16, -1, '0, rx, dv, de);
            checks++; if ((rx & mask) !== (exp_rx & mask)) begin errors++; $display("FAIL basic_rx[%0d] got %h want %h", f, rx, exp_rx); end
            checks++; if (dv !== int'(good)) begin errors++; $display("FAIL basic_vld[%0d] got %0d want %0d", f, dv, good); end
            checks++; if (de !== int'(!good)) begin errors++; $display("FAIL basic_err[%0d] got %0d want %0d", f, de, !good); end
            if (good) begin m_chnl = cmds[f][13:11]; m_cmd = cmds[f]; end
            checks++; if (chnl !== m_chnl) begin errors++; $display("FAIL basic_chnl[%0d] got %0d want %0d", f, chnl, m_chnl); end
            checks++; if (cmd_rcvd !== m_cmd) begin errors++; $display("FAIL basic_cmd_rcvd[%0d] got %h want %h", f, cmd_rcvd, m_cmd); end
            if (f == 1) begin
                checks++; if (rx !== 16'h0A5C) begin errors++; $display("FAIL basic_a5c got %h want 0a5c", rx); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] cmds [5];
        logic [15:0] rx, exp_rx, mask;
        int dv, de;
        bit good;
        apply_reset();
        set_ch(0, 12'h000);
        cmds[0] = {2'b00, CH_LFT_LD,  11'h000};
        cmds[1] = {2'b00, CH_RGHT_LD, 11'h000};
        cmds[2] = {2'b00, CH_STEER,   11'h000};
        cmds[3] = {2'b00, CH_BATT,    11'h000};
        cmds[4] = {2'b00, CH_LFT_LD,  11'h000};
        for (int f = 0; f < 5; f++) begin
            if (f == 1) begin
                set_ch(0, 12'h111); set_ch(4, 12'h444); set_ch(5, 12'h555); set_ch(6, 12'h666);
            end
            exp_rx = m_resp(); good = m_good(cmds[f], 16); mask = m_mask(16);
            spi_frame(cmds[f], 16, -1, '0, rx, dv, de);
            checks++; if ((rx & mask) !== (exp_rx & mask)) begin errors++; $display("FAIL rr_rx[%0d] got %h want %h", f, rx, exp_rx); end
            checks++; if (dv !== int'(good)) begin errors++; $display("FAIL rr_vld[%0d] got %0d want %0d", f, dv, good); end
            checks++; if (de !== int'(!good)) begin errors++; $display("FAIL rr_err[%0d] got %0d want %0d", f, de, !good); end
            if (good) begin m_chnl = cmds[f][13:11]; m_cmd = cmds[f]; end
            checks++; if (chnl !== m_chnl) begin errors++; $display("FAIL rr_chnl[%0d] got %0d want %0d", f, chnl, m_chnl); end
            checks++; if (cmd_rcvd !== m_cmd) begin errors++; $display("FAIL rr_cmd_rcvd[%0d] got %h want %h", f, cmd_rcvd, m_cmd); end
        end
    endtask

    task automatic test_malformed();
        logic [15:0] cmds [6];
        int nb [6];
        logic [15:0] rx, exp_rx, mask;
        int dv, de;
        bit good;
        cmds[0] = 16'h3000; nb[0] = 16;
        cmds[1] = 16'h2000; nb[1] = 10;
        cmds[2] = 16'h0000; nb[2] = 16;
        cmds[3] = 16'h3000; nb[3] = 16;
        cmds[4] = 16'hC000; nb[4] = 16;
        cmds[5] = 16'h2800; nb[5] = 17;
        set_ch(6, 12'h9B7);
        set_ch(0, 12'h3C1);
        for (int f = 0; f < 6; f++) begin
            exp_rx = m_resp(); good = m_good(cmds[f], nb[f]); mask = m_mask(nb[f]);
            spi_frame(cmds[f], nb[f], -1, '0, rx, dv, de);
            checks++; if ((rx & mask) !== (exp_rx & mask)) begin errors++; $display("FAIL bad_rx[%0d] got %h want %h", f, rx & mask, exp_rx & mask); end
            checks++; if (dv !== int'(good)) begin errors++; $display("FAIL bad_vld[%0d] got %0d want %0d", f, dv, good); end
            checks++; if (de !== int'(!good)) begin errors++; $display("FAIL bad_err[%0d] got %0d want %0d", f, de, !good); end
            if (good) begin m_chnl = cmds[f][13:11]; m_cmd = cmds[f]; end
            checks++; if (chnl !== m_chnl) begin errors++; $display("FAIL bad_chnl[%0d] got %0d want %0d", f, chnl, m_chnl); end
            checks++; if (cmd_rcvd !== m_cmd) begin errors++; $display("FAIL bad_cmd_rcvd[%0d] got %h want %h", f, cmd_rcvd, m_cmd); end
        end
    endtask

    task automatic test_sample_rule();
        logic [15:0] rx, exp_rx;
        int dv, de;
        set_ch(6, 12'h123);
        spi_frame(16'h3000, 16, -1, '0, rx, dv, de);
        m_chnl = 3'd6; m_cmd = 16'h3000;
        checks++; if (chnl !== 3'd6) begin errors++; $display("FAIL sample_chnl got %0d want 6", chnl); end
        exp_rx = m_resp();
        spi_frame(16'h0000, 16, 6, 12'h321, rx, dv, de);
        m_chnl = 3'd0; m_cmd = 16'h0000;
        checks++; if (rx !== exp_rx) begin errors++; $display("FAIL sample_rx got %h want %h", rx, exp_rx); end
        checks++; if (dv !== 1 || de !== 0) begin errors++; $display("FAIL sample_pulses got vld %0d err %0d want 1 0", dv, de); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] rx, exp_rx;
        int dv, de, v0, e0;
        spi_frame(16'h2800, 16, -1, '0, rx, dv, de);
        m_chnl = 3'd5; m_cmd = 16'h2800;
        set_ch(5, 12'hFFF);
        set_ch(0, 12'h5A3);
        @(negedge clk);
        spi.SS_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            spi.SCLK = 1'b0;
            spi.MOSI = 1'b1;
            repeat (5) @(negedge clk);
            spi.SCLK = 1'b1;
            repeat (5) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (spi.MISO !== 1'b0) begin errors++; $display("FAIL midrst_miso got %b want 0", spi.MISO); end
        checks++; if (chnl !== 3'd0) begin errors++; $display("FAIL midrst_chnl got %0d want 0", chnl); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL midrst_state got %0d want 0", state); end
        spi.SS_n = 1'b1;
        spi.MOSI = 1'b0;
        repeat (6) @(negedge clk);
        v0 = vld_cnt; e0 = err_cnt;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        m_chnl = 3'd0; m_cmd = 16'h0000;
        checks++; if (vld_cnt !== v0 || err_cnt !== e0) begin errors++; $display("FAIL midrst_pulses got vld %0d err %0d want 0 0", vld_cnt - v0, err_cnt - e0); end
        checks++; if (cmd_rcvd !== m_cmd) begin errors++; $display("FAIL midrst_cmd_rcvd got %h want %h", cmd_rcvd, m_cmd); end
        exp_rx = m_resp();
        spi_frame(16'h3000, 16, -1, '0, rx, dv, de);
        m_chnl = 3'd6; m_cmd = 16'h3000;
        checks++; if (rx !== exp_rx) begin errors++; $display("FAIL midrst_rx got %h want %h", rx, exp_rx); end
        checks++; if (chnl !== m_chnl) begin errors++; $display("FAIL midrst_next_chnl got %0d want %0d", chnl, m_chnl); end
    endtask

    task automatic test_random();
        logic [15:0] cmd, rx, exp_rx, mask;
        int nb, dv, de, r;
        bit good;
        for (int f = 0; f < 24; f++) begin
            for (int k = 0; k < NUM_CH; k++) set_ch(k, 12'($urandom_range(0, 4095)));
            cmd[15:14] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            cmd[13:11] = 3'($urandom_range(0, 7));
            cmd[10:0]  = 11'($urandom_range(0, 2047));
            r = $urandom_range(0, 7);
            nb = (r == 0) ? $urandom_range(1, 15) : (r == 1) ? 17 : 16;
            exp_rx = m_resp(); good = m_good(cmd, nb); mask = m_mask(nb);
            spi_frame(cmd, nb, -1, '0, rx, dv, de);
            checks++; if ((rx & mask) !== (exp_rx & mask)) begin errors++; $display("FAIL rand_rx[%0d] got %h want %h", f, rx & mask, exp_rx & mask); end
            checks++; if (dv !== int'(good)) begin errors++; $display("FAIL rand_vld[%0d] got %0d want %0d", f, dv, good); end
            checks++; if (de !== int'(!good)) begin errors++; $display("FAIL rand_err[%0d] got %0d want %0d", f, de, !good); end
            if (good) begin m_chnl = cmd[13:11]; m_cmd = cmd; end
            checks++; if (chnl !== m_chnl) begin errors++; $display("FAIL rand_chnl[%0d] got %0d want %0d", f, chnl, m_chnl); end
            checks++; if (cmd_rcvd !== m_cmd) begin errors++; $display("FAIL rand_cmd_rcvd[%0d] got %h want %h", f, cmd_rcvd, m_cmd); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        spi.SS_n = 1'b1;
        spi.SCLK = 1'b1;
        spi.MOSI = 1'b0;
        ch_data = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_malformed();
        test_sample_rule();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
